// File: rtl/axi_read_arbiter_if.sv
// Purpose: bundles the icache, dcache and bus AR/R channels of the read arbiter plus its status outputs.
// Latency: none; this is wiring only.
// Backpressure: carries the valid/ready pairs untouched; the slave modport is the arbiter's own view.
interface axi_read_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   // icache requester
   logic              ic_arvalid;
   logic [ADDR_W-1:0] ic_araddr;
   logic [7:0]        ic_arlen;
   logic [2:0]        ic_arsize;
   logic [1:0]        ic_arburst;
   logic              ic_arready;
   logic              ic_rvalid;
   logic              ic_rlast;
   logic [DATA_W-1:0] ic_rdata;
   logic              ic_rready;

   // dcache requester
   logic              dc_arvalid;
   logic [ADDR_W-1:0] dc_araddr;
   logic [7:0]        dc_arlen;
   logic [2:0]        dc_arsize;
   logic [1:0]        dc_arburst;
   logic              dc_arready;
   logic              dc_rvalid;
   logic              dc_rlast;
   logic [DATA_W-1:0] dc_rdata;
   logic              dc_rready;

   // shared bus read master
   logic              m_axi_arvalid;
   logic [ADDR_W-1:0] m_axi_araddr;
   logic [7:0]        m_axi_arlen;
   logic [2:0]        m_axi_arsize;
   logic [1:0]        m_axi_arburst;
   logic              m_axi_arready;
   logic              m_axi_rvalid;
   logic              m_axi_rlast;
   logic [DATA_W-1:0] m_axi_rdata;
   logic              m_axi_rready;

   // status
   logic [1:0]        owner;
   logic              burst_err;

   // Arbiter side.
   modport slave (
      input  ic_arvalid, ic_araddr, ic_arlen, ic_arsize, ic_arburst, ic_rready,
      output ic_arready, ic_rvalid, ic_rlast, ic_rdata,
      input  dc_arvalid, dc_araddr, dc_arlen, dc_arsize, dc_arburst, dc_rready,
      output dc_arready, dc_rvalid, dc_rlast, dc_rdata,
      output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready,
      input  m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rdata,
      output owner, burst_err
   );

   // Environment side: both requesters, the bus slave and the status observer.
   modport master (
      output ic_arvalid, ic_araddr, ic_arlen, ic_arsize, ic_arburst, ic_rready,
      input  ic_arready, ic_rvalid, ic_rlast, ic_rdata,
      output dc_arvalid, dc_araddr, dc_arlen, dc_arsize, dc_arburst, dc_rready,
      input  dc_arready, dc_rvalid, dc_rlast, dc_rdata,
      input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready,
      output m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rdata,
      input  owner, burst_err
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// Purpose: shares one AXI read master between icache and dcache miss paths, one burst in flight at a time.
// Latency: bus arvalid 1 cycle after the requester AR handshake; R beats pass through combinationally.
// Backpressure: owner rready drives bus rready directly (no buffering); one idle cycle after each rlast.
module axi_read_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input logic              clk,
   input logic              reset,
   axi_read_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_IC   = 2'b01;
   localparam logic [1:0] OWN_DC   = 2'b10;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [ADDR_W-1:0] r_araddr;
   logic [7:0]        r_arlen;
   logic [2:0]        r_arsize;
   logic [1:0]        r_arburst;
   logic [1:0]        r_owner;
   logic              r_last_dc;   // 1 = dcache held the most recent grant
   logic [7:0]        r_cnt;       // beats already accepted in this burst
   logic              r_burst_err;

   logic              w_rst_act;
   logic              w_ic_win;
   logic              w_dc_win;
   logic              w_grant;
   logic              w_beat;
   logic              w_beat_last;
   logic              w_own_ic;
   logic              w_own_dc;

   // Combinational outputs must be quiet while reset is held, even if requesters are asserting arvalid.
   assign w_rst_act = ~reset;

   // Round-robin between the two requesters: on a tie the one that did not win last time goes.
   always_comb begin
      w_ic_win = 1'b0;
      w_dc_win = 1'b0;
      if (r_state == ST_IDLE && !w_rst_act) begin
         w_ic_win = bus.ic_arvalid && (!bus.dc_arvalid || r_last_dc);
         w_dc_win = bus.dc_arvalid && (!bus.ic_arvalid || !r_last_dc);
      end
   end

   assign w_grant     = w_ic_win | w_dc_win;
   assign w_own_ic    = (r_state == ST_DATA) && (r_owner == OWN_IC);
   assign w_own_dc    = (r_state == ST_DATA) && (r_owner == OWN_DC);
   assign w_beat      = (r_state == ST_DATA) && bus.m_axi_rvalid && bus.m_axi_rready;
   assign w_beat_last = w_beat && bus.m_axi_rlast;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: grant -> address phase -> data phase until the rlast beat is taken.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_grant)            w_state_nxt = ST_ADDR;
         ST_ADDR: if (bus.m_axi_arready)  w_state_nxt = ST_DATA;
         ST_DATA: if (w_beat_last)        w_state_nxt = ST_IDLE;
         default:                         w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: AR from latched request in ADDR, R routed to the owner in DATA, everything else zero.
   always_comb begin
      bus.ic_arready    = w_ic_win;
      bus.dc_arready    = w_dc_win;
      bus.m_axi_arvalid = 1'b0;
      bus.m_axi_araddr  = '0;
      bus.m_axi_arlen   = '0;
      bus.m_axi_arsize  = '0;
      bus.m_axi_arburst = '0;
      bus.m_axi_rready  = 1'b0;
      bus.ic_rvalid     = 1'b0;
      bus.ic_rlast      = 1'b0;
      bus.ic_rdata      = '0;
      bus.dc_rvalid     = 1'b0;
      bus.dc_rlast      = 1'b0;
      bus.dc_rdata      = '0;
      if (r_state == ST_ADDR) begin
         bus.m_axi_arvalid = 1'b1;
         bus.m_axi_araddr  = r_araddr;
         bus.m_axi_arlen   = r_arlen;
         bus.m_axi_arsize  = r_arsize;
         bus.m_axi_arburst = r_arburst;
      end
      if (w_own_ic) begin
         bus.m_axi_rready = bus.ic_rready;
         bus.ic_rvalid    = bus.m_axi_rvalid;
         bus.ic_rlast     = bus.m_axi_rlast;
         bus.ic_rdata     = bus.m_axi_rdata;
      end
      if (w_own_dc) begin
         bus.m_axi_rready = bus.dc_rready;
         bus.dc_rvalid    = bus.m_axi_rvalid;
         bus.dc_rlast     = bus.m_axi_rlast;
         bus.dc_rdata     = bus.m_axi_rdata;
      end
   end

   assign bus.owner     = r_owner;
   assign bus.burst_err = r_burst_err;

   // Request capture on grant; beat counting and sticky length check during the data phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_araddr    <= '0;
         r_arlen     <= '0;
         r_arsize    <= '0;
         r_arburst   <= '0;
         r_owner     <= OWN_NONE;
         r_last_dc   <= 1'b1;
         r_cnt       <= '0;
         r_burst_err <= 1'b0;
      end else begin
         if (w_ic_win) begin
            r_araddr  <= bus.ic_araddr;
            r_arlen   <= bus.ic_arlen;
            r_arsize  <= bus.ic_arsize;
            r_arburst <= bus.ic_arburst;
            r_owner   <= OWN_IC;
            r_last_dc <= 1'b0;
            r_cnt     <= '0;
         end else if (w_dc_win) begin
            r_araddr  <= bus.dc_araddr;
            r_arlen   <= bus.dc_arlen;
            r_arsize  <= bus.dc_arsize;
            r_arburst <= bus.dc_arburst;
            r_owner   <= OWN_DC;
            r_last_dc <= 1'b1;
            r_cnt     <= '0;
         end
         if (w_beat) begin
            // Saturate so an overlong burst cannot wrap back into the "expected" range.
            if (r_cnt != 8'hFF) begin
               r_cnt <= r_cnt + 8'd1;
            end
            if (bus.m_axi_rlast) begin
               r_owner <= OWN_NONE;
               if (r_cnt != r_arlen) begin
                  r_burst_err <= 1'b1;
               end
            end else if (r_cnt >= r_arlen) begin
               r_burst_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI read master port between the instruction-cache miss path and the data-cache miss path.
- Accepts one AR request at a time from either requester and forwards it to the bus.
- Routes the returned R burst back to the owning requester and holds the grant until the last beat.
- Sits between both recache instances and the top-level m_axi_* read channel.

Parameters:
ADDR_W, 64, address width of araddr on all ports
DATA_W, 64, data width of rdata on all ports

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ic_arvalid  input  1  icache read-address valid
ic_araddr  input  ADDR_W  icache burst start address
ic_arlen  input  8  icache burst length minus one
ic_arsize  input  3  icache beat size
ic_arburst  input  2  icache burst type
ic_arready  output  1  icache request accepted
ic_rvalid  output  1  read beat valid to icache
ic_rlast  output  1  last beat to icache
ic_rdata  output  DATA_W  read data to icache
ic_rready  input  1  icache ready for beat
dc_arvalid, dc_araddr, dc_arlen, dc_arsize, dc_arburst, dc_arready, dc_rvalid, dc_rlast, dc_rdata, dc_rready  (same directions/widths)  dcache equivalents
m_axi_arvalid  output  1  bus read-address valid
m_axi_araddr  output  ADDR_W  bus address
m_axi_arlen  output  8  bus burst length
m_axi_arsize  output  3  bus beat size
m_axi_arburst  output  2  bus burst type
m_axi_arready  input  1  bus address accepted
m_axi_rvalid  input  1  bus beat valid
m_axi_rlast  input  1  bus last beat
m_axi_rdata  input  DATA_W  bus data
m_axi_rready  output  1  ready to bus
owner  output  2  00 none, 01 icache, 10 dcache (current grant)
burst_err  output  1  sticky: rlast/beat-count mismatch seen

Behaviour:
- States: IDLE, ADDR, DATA.
- Reset is asynchronous on reset==0 and takes priority over everything else:
  - state=IDLE, owner=00, burst_err=0, last_grant=DC, beat counter=0.
  - All valid/ready outputs=0; all data/address outputs=0.
  - An in-flight burst is abandoned; no beats are forwarded after reset.
- IDLE:
  - Arbitrate combinationally among ic_arvalid and dc_arvalid.
  - Only one valid: that requester wins.
  - Both valid: winner is the requester not equal to last_grant (round-robin). Because last_grant resets to DC, icache wins the first tie.
  - Winner's arready=1 in the same cycle (the AR handshake completes there); the loser's arready=0.
  - On that edge: latch araddr/arlen/arsize/arburst into registers, set owner, set last_grant=winner, clear the beat counter, move to ADDR.
  - No valid requester: stay in IDLE, all arready=0.
- ADDR:
  - m_axi_arvalid=1; m_axi_ar* come from registers and stay stable until m_axi_arready.
  - On m_axi_arvalid&&m_axi_arready, move to DATA.
  - First bus arvalid appears exactly 1 cycle after the requester handshake.
- DATA:
  - m_axi_rready = owner's rready.
  - Owner's rvalid = m_axi_rvalid; owner's rlast = m_axi_rlast; owner's rdata = m_axi_rdata.
  - The non-owner sees rvalid=0, rlast=0, rdata=0.
  - Each m_axi_rvalid&&m_axi_rready increments the 8-bit beat counter.
  - On a beat with rlast=1: go to IDLE and set owner=00.
  - If count != latched arlen at that beat, set burst_err=1.
  - If a beat arrives after count==arlen without rlast, also set burst_err=1; stay in DATA until rlast.
- Requester ar* inputs are ignored outside IDLE; arready=0 outside IDLE.
- New requests are not accepted in the cycle the rlast beat completes. IDLE is re-entered the next cycle, so back-to-back bursts have a 1-cycle gap.
- Owner backpressure (rready=0) stalls the bus; the bus must hold its beat. The arbiter adds no buffering.
- m_axi_arvalid=0 in IDLE and DATA; m_axi_rready=0 in IDLE and ADDR.

Test Plan:
- Single icache request: ic_arvalid with araddr=0x1000, arlen=7, m_axi_arready held 1, 8 beats of data 0..7 with rlast on beat 8 -> ic_arready pulses 1 cycle; m_axi_arvalid the next cycle with araddr=0x1000, arlen=7; icache receives data 0..7 and rlast; dcache rvalid stays 0; owner returns to 00; burst_err=0.
- Simultaneous ic/dc arvalid after reset -> icache granted first (owner=01). After its rlast, dcache is granted (owner=10) with no icache re-request in between.
- Both requesters hold arvalid continuously for 4 bursts -> grant order IC, DC, IC, DC, with exactly 1 idle cycle between each rlast and the next arready.
- m_axi_arready withheld 5 cycles -> m_axi_arvalid stays 1 and m_axi_araddr stays constant for all 5 cycles. Changing dc_araddr during this time does not affect m_axi_araddr.
- Owner rready toggling 1/0 during a 4-beat burst -> m_axi_rready mirrors it; the beat count advances only on handshakes; all 4 beats are delivered in order.
- Bus rlast on beat 3 of arlen=7 -> burst_err=1 and sticky; return to IDLE. Asserting reset=0 mid-DATA in a separate burst -> all outputs 0 immediately and burst_err cleared.
